// File: rtl/nx_indirect_access_cntrl_v3.sv
// -----------------------------------------------------------------------------
// nx_indirect_access_cntrl_v3
//
// Multi-table indirect-access controller. A CSR write to CMND_ADDRESS issues a
// command. The controller turns that command into single-port accesses on a
// shared memory port. Those accesses use grant/rsp handshakes, and a timer
// supervises each one. The block keeps a per-table enable state, a latched
// command context and a programmable start address for INIT sweeps.
//
// Optional feature: define NX_IA_ERR_CNT_EN to build a saturating error
// counter on err_cnt. Without the macro, err_cnt is tied to zero.
//
// Handshake: sw_cs is a request that is held until grant is sampled high.
// sw_add, sw_table_id, sw_wdat and sw_we stay stable while sw_cs is high.
// For a READ, the grant ends the request. A later single-cycle rsp then
// delivers sw_rdat. In a sweep, each cycle that has sw_cs and grant high
// completes one write.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_stb, reg_addr      CSR write strobe / address
//   cmnd_op               command opcode
//   cmnd_addr             command entry address
//   cmnd_table_id         command target table
//   wr_dat                write / init data
//   addr_limit            highest legal address, per table
//   stat_code             RDY/BSY/TMO/OVR/NXM/UOP/DIS
//   stat_addr/_table_id   latched command context
//   rd_dat                last read result
//   enable                per-table enable
//   sw_cs/we/table_id/add/wdat   memory access request
//   sw_rdat, grant, rsp   memory response
//   yield                 timer MSB, priority hint to the arbiter
//   err_cnt               error counter (optional)
//   dbg_state             FSM state, for observation
// -----------------------------------------------------------------------------
module nx_indirect_access_cntrl_v3 #(
    parameter int                     CMND_ADDRESS    = 0,
    parameter int                     N_REG_ADDR_BITS = 16,
    parameter int                     N_DATA_BITS     = 64,
    parameter int                     N_TABLES        = 4,
    parameter int                     N_ENTRIES       = 1024,
    parameter int                     N_TIMER_BITS    = 6,
    parameter logic [N_DATA_BITS-1:0] RESET_DATA      = '0,
    localparam int                    AW              = $clog2(N_ENTRIES),
    localparam int                    TW              = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_stb,
    input  logic [N_REG_ADDR_BITS-1:0]    reg_addr,
    input  logic [3:0]                    cmnd_op,
    input  logic [AW-1:0]                 cmnd_addr,
    input  logic [TW-1:0]                 cmnd_table_id,
    input  logic [N_DATA_BITS-1:0]        wr_dat,
    input  logic [N_TABLES-1:0][AW-1:0]   addr_limit,
    output logic [2:0]                    stat_code,
    output logic [AW-1:0]                 stat_addr,
    output logic [TW-1:0]                 stat_table_id,
    output logic [N_DATA_BITS-1:0]        rd_dat,
    output logic [N_TABLES-1:0]           enable,
    output logic                          sw_cs,
    output logic                          sw_we,
    output logic [TW-1:0]                 sw_table_id,
    output logic [AW-1:0]                 sw_add,
    output logic [N_DATA_BITS-1:0]        sw_wdat,
    input  logic [N_DATA_BITS-1:0]        sw_rdat,
    input  logic                          grant,
    input  logic                          rsp,
    output logic                          yield,
    output logic [7:0]                    err_cnt,
    output logic [2:0]                    dbg_state
);

    typedef enum logic [2:0] {
        ST_READY    = 3'd0,
        ST_ACCESS   = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_SWEEP    = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    localparam logic [2:0] C_RDY = 3'd0, C_BSY = 3'd1, C_TMO = 3'd2, C_OVR = 3'd3,
                           C_NXM = 3'd4, C_UOP = 3'd5, C_DIS = 3'd6;

    localparam logic [3:0] OP_NOP = 4'h0, OP_READ = 4'h1, OP_WRITE = 4'h2,
                           OP_ENABLE = 4'h3, OP_DISABLE = 4'h4, OP_RESET = 4'h5,
                           OP_INIT = 4'h6, OP_SET_INIT = 4'h8, OP_ACK = 4'hF;

    state_t                  r_state, w_nxt_state;
    logic [2:0]              r_stat_code, w_nxt_code;
    logic [N_TIMER_BITS-1:0] r_timer, w_nxt_timer;
    logic [3:0]              r_op;
    logic [AW-1:0]           r_stat_addr;
    logic [TW-1:0]           r_stat_table_id;
    logic [N_DATA_BITS-1:0]  r_rd_dat;
    logic [N_TABLES-1:0]     r_enable;
    logic                    r_sw_cs;
    logic                    r_sw_we;
    logic [TW-1:0]           r_sw_table_id;
    logic [AW-1:0]           r_sw_add;
    logic [N_DATA_BITS-1:0]  r_sw_wdat;
    logic [AW-1:0]           r_end_addr;
    logic [AW-1:0]           r_init_start;

    // Command decode
    logic          w_issue, w_ovr, w_tbl_ok, w_enabled;
    logic          w_uses_table, w_uses_addr, w_is_access, w_known;
    logic          w_nxm, w_dis;
    logic [AW-1:0] w_limit;

    // Actions selected by the next-state logic
    logic w_accept, w_start, w_en_set, w_en_clr, w_set_init, w_clr_init;
    logic w_load_rd, w_adv, w_nxt_cs, w_nxt_we, w_write_op;

    assign w_issue = wr_stb && (reg_addr == N_REG_ADDR_BITS'(CMND_ADDRESS)) && (cmnd_op != OP_NOP);
    // While busy, any real command except ACK_ERROR is an overrun.
    assign w_ovr   = w_issue && (cmnd_op != OP_ACK);

    assign w_tbl_ok  = int'(cmnd_table_id) < N_TABLES;
    assign w_limit   = w_tbl_ok ? addr_limit[cmnd_table_id] : '0;
    assign w_enabled = w_tbl_ok && r_enable[cmnd_table_id];

    assign w_uses_addr  = (cmnd_op == OP_READ) || (cmnd_op == OP_WRITE) || (cmnd_op == OP_INIT);
    assign w_is_access  = w_uses_addr || (cmnd_op == OP_RESET);
    assign w_uses_table = w_is_access || (cmnd_op == OP_ENABLE) || (cmnd_op == OP_DISABLE);
    assign w_known      = w_uses_table || (cmnd_op == OP_SET_INIT) || (cmnd_op == OP_ACK);

    // RESET sweeps the whole table, so only the table id is range-checked for it.
    assign w_nxm = (w_uses_table && !w_tbl_ok)
                || (w_uses_addr && (cmnd_addr > w_limit))
                || ((cmnd_op == OP_INIT) && (r_init_start > cmnd_addr));
    assign w_dis = w_is_access && !w_enabled;

    // Next-state / action logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_code  = r_stat_code;
        w_nxt_timer = '0;
        w_accept    = 1'b0;
        w_en_set    = 1'b0;
        w_en_clr    = 1'b0;
        w_set_init  = 1'b0;
        w_clr_init  = 1'b0;
        w_load_rd   = 1'b0;
        w_adv       = 1'b0;
        unique case (r_state)
            ST_READY: begin
                if (w_issue && (cmnd_op != OP_ACK)) begin
                    w_accept = 1'b1;
                    if (!w_known) begin
                        w_nxt_state = ST_ERROR;
                        w_nxt_code  = C_UOP;
                    end else if (w_nxm) begin
                        w_nxt_state = ST_ERROR;
                        w_nxt_code  = C_NXM;
                    end else if (w_dis) begin
                        w_nxt_state = ST_ERROR;
                        w_nxt_code  = C_DIS;
                    end else begin
                        unique case (cmnd_op)
                            OP_READ, OP_WRITE: begin
                                w_nxt_state = ST_ACCESS;
                                w_nxt_code  = C_BSY;
                                w_nxt_timer = N_TIMER_BITS'(1);
                            end
                            OP_RESET, OP_INIT: begin
                                w_nxt_state = ST_SWEEP;
                                w_nxt_code  = C_BSY;
                                w_nxt_timer = N_TIMER_BITS'(1);
                            end
                            OP_ENABLE:   w_en_set   = 1'b1;
                            OP_DISABLE:  w_en_clr   = 1'b1;
                            OP_SET_INIT: w_set_init = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_ACCESS, ST_WAIT_RSP, ST_SWEEP: begin
                // Priority: overrun, then handshake, then timeout (grant beats timeout).
                if (w_ovr) begin
                    w_nxt_state = ST_ERROR;
                    w_nxt_code  = C_OVR;
                end else if ((r_state == ST_ACCESS) && grant) begin
                    if (r_op == OP_WRITE) begin
                        w_nxt_state = ST_READY;
                        w_nxt_code  = C_RDY;
                    end else begin
                        w_nxt_state = ST_WAIT_RSP;
                    end
                end else if ((r_state == ST_WAIT_RSP) && rsp) begin
                    w_nxt_state = ST_READY;
                    w_nxt_code  = C_RDY;
                    w_load_rd   = 1'b1;
                end else if ((r_state == ST_SWEEP) && grant) begin
                    if (r_sw_add == r_end_addr) begin
                        w_nxt_state = ST_READY;
                        w_nxt_code  = C_RDY;
                        w_clr_init  = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end else if (r_timer == '1) begin
                    w_nxt_state = ST_ERROR;
                    w_nxt_code  = C_TMO;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            ST_ERROR: begin
                if (w_issue && (cmnd_op == OP_ACK)) begin
                    w_nxt_state = ST_READY;
                    w_nxt_code  = C_RDY;
                end
            end
            default: begin
                w_nxt_state = ST_READY;
                w_nxt_code  = C_RDY;
            end
        endcase
    end

    assign w_start    = (r_state == ST_READY) &&
                        ((w_nxt_state == ST_ACCESS) || (w_nxt_state == ST_SWEEP));
    assign w_write_op = (r_state == ST_READY) ? (cmnd_op == OP_WRITE) : (r_op == OP_WRITE);
    assign w_nxt_cs   = (w_nxt_state == ST_ACCESS) || (w_nxt_state == ST_SWEEP);
    assign w_nxt_we   = (w_nxt_state == ST_SWEEP) || ((w_nxt_state == ST_ACCESS) && w_write_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_READY;
        else        r_state <= w_nxt_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_code     <= C_RDY;
            r_timer         <= '0;
            r_op            <= OP_NOP;
            r_stat_addr     <= '0;
            r_stat_table_id <= '0;
            r_rd_dat        <= RESET_DATA;
            r_enable        <= '0;
            r_sw_cs         <= 1'b0;
            r_sw_we         <= 1'b0;
            r_sw_table_id   <= '0;
            r_sw_add        <= '0;
            r_sw_wdat       <= '0;
            r_end_addr      <= '0;
            r_init_start    <= '0;
        end else begin
            r_stat_code <= w_nxt_code;
            r_timer     <= w_nxt_timer;
            r_sw_cs     <= w_nxt_cs;
            r_sw_we     <= w_nxt_we;
            if (w_accept) begin
                r_op            <= cmnd_op;
                r_stat_addr     <= cmnd_addr;
                r_stat_table_id <= cmnd_table_id;
            end
            if (w_start) begin
                r_sw_table_id <= cmnd_table_id;
                unique case (cmnd_op)
                    OP_RESET: begin
                        r_sw_add   <= '0;
                        r_end_addr <= w_limit;
                        r_sw_wdat  <= RESET_DATA;
                    end
                    OP_INIT: begin
                        r_sw_add   <= r_init_start;
                        r_end_addr <= cmnd_addr;
                        r_sw_wdat  <= wr_dat;
                    end
                    default: begin
                        r_sw_add   <= cmnd_addr;
                        r_end_addr <= cmnd_addr;
                        r_sw_wdat  <= wr_dat;
                    end
                endcase
            end else if (w_adv) begin
                r_sw_add <= r_sw_add + 1'b1;
            end
            if (w_load_rd)  r_rd_dat <= sw_rdat;
            if (w_en_set)   r_enable[cmnd_table_id] <= 1'b1;
            if (w_en_clr)   r_enable[cmnd_table_id] <= 1'b0;
            if (w_set_init) r_init_start <= cmnd_addr;
            else if (w_clr_init) r_init_start <= '0;
        end
    end

`ifdef NX_IA_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if ((r_state != ST_ERROR) && (w_nxt_state == ST_ERROR)) begin
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else if ((r_state == ST_ERROR) && (w_nxt_state == ST_READY) && (cmnd_addr == '0)) begin
            r_err_cnt <= 8'd0;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign stat_code     = r_stat_code;
    assign stat_addr     = r_stat_addr;
    assign stat_table_id = r_stat_table_id;
    assign rd_dat        = r_rd_dat;
    assign enable        = r_enable;
    assign sw_cs         = r_sw_cs;
    assign sw_we         = r_sw_we;
    assign sw_table_id   = r_sw_table_id;
    assign sw_add        = r_sw_add;
    assign sw_wdat       = r_sw_wdat;
    assign yield         = r_timer[N_TIMER_BITS-1];
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_nx_indirect_access_cntrl_v3.sv
// -----------------------------------------------------------------------------
// Testbench for nx_indirect_access_cntrl_v3 with the default parameters
// (AW=10, TW=2, 64-bit data, 6-bit timer). The expected values below are
// computed by hand.
// -----------------------------------------------------------------------------
module tb_nx_indirect_access_cntrl_v3;

    localparam logic [63:0] RESET_DATA = 64'h0;
    localparam logic [3:0] OP_READ = 4'h1, OP_WRITE = 4'h2, OP_ENABLE = 4'h3,
                           OP_DISABLE = 4'h4, OP_RESET = 4'h5, OP_INIT = 4'h6,
                           OP_SET_INIT = 4'h8, OP_ACK = 4'hF;
    localparam logic [2:0] C_RDY = 3'd0, C_BSY = 3'd1, C_TMO = 3'd2, C_OVR = 3'd3,
                           C_NXM = 3'd4, C_UOP = 3'd5, C_DIS = 3'd6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_stb;
    logic [15:0]     reg_addr;
    logic [3:0]      cmnd_op;
    logic [9:0]      cmnd_addr;
    logic [1:0]      cmnd_table_id;
    logic [63:0]     wr_dat;
    logic [3:0][9:0] addr_limit;
    logic [2:0]      stat_code;
    logic [9:0]      stat_addr;
    logic [1:0]      stat_table_id;
    logic [63:0]     rd_dat;
    logic [3:0]      enable;
    logic            sw_cs, sw_we;
    logic [1:0]      sw_table_id;
    logic [9:0]      sw_add;
    logic [63:0]     sw_wdat;
    logic [63:0]     sw_rdat;
    logic            grant, rsp;
    logic            yield;
    logic [7:0]      err_cnt;
    logic [2:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  exp_q[$];
    logic [9:0]  got_add_q[$];
    logic [63:0] got_wdat_q[$];

    nx_indirect_access_cntrl_v3 dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .reg_addr(reg_addr),
        .cmnd_op(cmnd_op), .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id),
        .wr_dat(wr_dat), .addr_limit(addr_limit), .stat_code(stat_code),
        .stat_addr(stat_addr), .stat_table_id(stat_table_id), .rd_dat(rd_dat),
        .enable(enable), .sw_cs(sw_cs), .sw_we(sw_we), .sw_table_id(sw_table_id),
        .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat), .grant(grant),
        .rsp(rsp), .yield(yield), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers. Inputs change 1 time unit after posedge, and so do samples.
    task automatic issue(input logic [3:0] op, input logic [1:0] tbl,
                         input logic [9:0] addr, input logic [63:0] dat);
        wr_stb = 1'b1; reg_addr = 16'h0; cmnd_op = op;
        cmnd_table_id = tbl; cmnd_addr = addr; wr_dat = dat;
        @(posedge clk); #1;
        // Scramble the inputs to show that the command context was latched.
        wr_stb = 1'b0; cmnd_op = 4'h0; cmnd_table_id = 2'd3;
        cmnd_addr = 10'h3FF; wr_dat = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Hold grant high and record every write while sw_cs stays high.
    task automatic collect_sweep(input int max_cyc, output int used);
        got_add_q.delete(); got_wdat_q.delete();
        grant = 1'b1;
        used = 0;
        while ((sw_cs === 1'b1) && (used < max_cyc)) begin
            if (sw_we === 1'b1) begin
                got_add_q.push_back(sw_add);
                got_wdat_q.push_back(sw_wdat);
            end
            @(posedge clk); #1;
            used++;
        end
        grant = 1'b0;
    endtask

    // Tests
    task automatic test_reset;
        rst_n = 1'b0; wr_stb = 1'b0; reg_addr = '0; cmnd_op = '0; cmnd_addr = '0;
        cmnd_table_id = '0; wr_dat = '0; sw_rdat = '0; grant = 1'b0; rsp = 1'b0;
        addr_limit[0] = 10'd7; addr_limit[1] = 10'd7;
        addr_limit[2] = 10'd15; addr_limit[3] = 10'd1023;
        tick(3);
        n_checks++; if (stat_code !== C_RDY) begin n_fail++; $display("FAIL reset_stat_code: got %0d expected %0d", stat_code, C_RDY); end
        n_checks++; if (enable !== 4'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0000", enable); end
        n_checks++; if (rd_dat !== RESET_DATA) begin n_fail++; $display("FAIL reset_rd_dat: got %h expected %h", rd_dat, RESET_DATA); end
        n_checks++; if ({sw_cs, sw_we} !== 2'b00) begin n_fail++; $display("FAIL reset_sw_cs_we: got %b expected 00", {sw_cs, sw_we}); end
        n_checks++; if ({sw_add, sw_table_id} !== 12'h0) begin n_fail++; $display("FAIL reset_sw_addr: got %h expected 0", {sw_add, sw_table_id}); end
        n_checks++; if (sw_wdat !== 64'h0) begin n_fail++; $display("FAIL reset_sw_wdat: got %h expected 0", sw_wdat); end
        n_checks++; if ({stat_addr, stat_table_id} !== 12'h0) begin n_fail++; $display("FAIL reset_stat_ctx: got %h expected 0", {stat_addr, stat_table_id}); end
        n_checks++; if ({yield, err_cnt} !== 9'h0) begin n_fail++; $display("FAIL reset_yield_err: got %h expected 0", {yield, err_cnt}); end
        n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_write_read;
        int cs_cycles;
        issue(OP_ENABLE, 2'd2, 10'd0, 64'h0);
        n_checks++; if (enable !== 4'b0100) begin n_fail++; $display("FAIL enable_t2: got %b expected 0100", enable); end
        // A write strobe to a different register address is not a command.
        wr_stb = 1'b1; reg_addr = 16'h1; cmnd_op = OP_ENABLE; cmnd_table_id = 2'd3;
        tick(1);
        wr_stb = 1'b0; reg_addr = 16'h0;
        n_checks++; if (enable !== 4'b0100) begin n_fail++; $display("FAIL wrong_reg_addr: got %b expected 0100", enable); end

        issue(OP_WRITE, 2'd2, 10'd5, 64'hA5A5);
        n_checks++; if ({sw_cs, sw_we, sw_table_id, sw_add} !== {1'b1, 1'b1, 2'd2, 10'd5}) begin n_fail++; $display("FAIL write_req: got cs%b we%b t%0d a%0d expected cs1 we1 t2 a5", sw_cs, sw_we, sw_table_id, sw_add); end
        n_checks++; if (stat_code !== C_BSY) begin n_fail++; $display("FAIL write_busy: got %0d expected %0d", stat_code, C_BSY); end
        cs_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (sw_cs === 1'b1) cs_cycles++;
            n_checks++; if (sw_wdat !== 64'hA5A5) begin n_fail++; $display("FAIL write_wdat_stable: got %h expected a5a5", sw_wdat); end
            grant = (i == 2);
            tick(1);
        end
        grant = 1'b0;
        n_checks++; if (cs_cycles !== 3) begin n_fail++; $display("FAIL write_cs_cycles: got %0d expected 3", cs_cycles); end
        n_checks++; if ({sw_cs, stat_code} !== {1'b0, C_RDY}) begin n_fail++; $display("FAIL write_done: got cs%b code%0d expected cs0 code0", sw_cs, stat_code); end
        n_checks++; if ({stat_table_id, stat_addr} !== {2'd2, 10'd5}) begin n_fail++; $display("FAIL write_stat_ctx: got t%0d a%0d expected t2 a5", stat_table_id, stat_addr); end

        issue(OP_READ, 2'd2, 10'd5, 64'h0);
        n_checks++; if ({sw_cs, sw_we} !== 2'b10) begin n_fail++; $display("FAIL read_req: got %b expected 10", {sw_cs, sw_we}); end
        grant = 1'b1;
        tick(1);
        grant = 1'b0;
        n_checks++; if ({sw_cs, stat_code} !== {1'b0, C_BSY}) begin n_fail++; $display("FAIL read_wait_rsp: got cs%b code%0d expected cs0 code1", sw_cs, stat_code); end
        tick(1);
        sw_rdat = 64'hA5A5; rsp = 1'b1;
        tick(1);
        rsp = 1'b0; sw_rdat = 64'h0;
        n_checks++; if (rd_dat !== 64'hA5A5) begin n_fail++; $display("FAIL read_data: got %h expected a5a5", rd_dat); end
        n_checks++; if (stat_code !== C_RDY) begin n_fail++; $display("FAIL read_done: got %0d expected 0", stat_code); end
    endtask

    task automatic test_reset_sweep;
        int used;
        issue(OP_ENABLE, 2'd1, 10'd0, 64'h0);
        issue(OP_RESET, 2'd1, 10'd0, 64'h0);
        collect_sweep(20, used);
        exp_q.delete();
        for (int a = 0; a <= 7; a++) exp_q.push_back(10'(a));
        n_checks++; if (got_add_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_sweep_count: got %0d writes expected %0d", got_add_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_add_q.size(); i++) begin
            n_checks++; if (got_add_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL reset_sweep_addr[%0d]: got %0d expected %0d", i, got_add_q[i], exp_q[i]); end
            n_checks++; if (got_wdat_q[i] !== RESET_DATA) begin n_fail++; $display("FAIL reset_sweep_wdat[%0d]: got %h expected %h", i, got_wdat_q[i], RESET_DATA); end
        end
        n_checks++; if ({sw_cs, stat_code} !== {1'b0, C_RDY}) begin n_fail++; $display("FAIL reset_sweep_done: got cs%b code%0d expected cs0 code0", sw_cs, stat_code); end
    endtask

    task automatic test_init;
        int used;
        issue(OP_SET_INIT, 2'd1, 10'd3, 64'h0);
        n_checks++; if ({sw_cs, stat_code} !== {1'b0, C_RDY}) begin n_fail++; $display("FAIL set_init_no_access: got cs%b code%0d expected cs0 code0", sw_cs, stat_code); end
        issue(OP_INIT, 2'd1, 10'd6, 64'h11);
        collect_sweep(20, used);
        exp_q.delete();
        for (int a = 3; a <= 6; a++) exp_q.push_back(10'(a));
        n_checks++; if (got_add_q.size() != exp_q.size()) begin n_fail++; $display("FAIL init_count: got %0d writes expected %0d", got_add_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_add_q.size(); i++) begin
            n_checks++; if (got_add_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL init_addr[%0d]: got %0d expected %0d", i, got_add_q[i], exp_q[i]); end
            n_checks++; if (got_wdat_q[i] !== 64'h11) begin n_fail++; $display("FAIL init_wdat[%0d]: got %h expected 11", i, got_wdat_q[i]); end
        end
        // The start address has returned to 0, so this sweep covers 0..1.
        issue(OP_INIT, 2'd1, 10'd1, 64'h22);
        collect_sweep(20, used);
        exp_q.delete();
        exp_q.push_back(10'd0); exp_q.push_back(10'd1);
        n_checks++; if (got_add_q.size() != exp_q.size()) begin n_fail++; $display("FAIL init2_count: got %0d writes expected %0d", got_add_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_add_q.size(); i++) begin
            n_checks++; if (got_add_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL init2_addr[%0d]: got %0d expected %0d", i, got_add_q[i], exp_q[i]); end
        end
        n_checks++; if (stat_code !== C_RDY) begin n_fail++; $display("FAIL init2_done: got %0d expected 0", stat_code); end
    endtask

    task automatic test_errors;
        // READ on disabled table 0
        issue(OP_READ, 2'd0, 10'd0, 64'h0);
        n_checks++; if (stat_code !== C_DIS) begin n_fail++; $display("FAIL dis_code: got %0d expected %0d", stat_code, C_DIS); end
        tick(1);
        n_checks++; if (sw_cs !== 1'b0) begin n_fail++; $display("FAIL dis_no_access: got %b expected 0", sw_cs); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        n_checks++; if (stat_code !== C_RDY) begin n_fail++; $display("FAIL ack_dis: got %0d expected 0", stat_code); end
        // Address above the table limit (limit[1]=7)
        issue(OP_READ, 2'd1, 10'd9, 64'h0);
        n_checks++; if ({stat_code, sw_cs} !== {C_NXM, 1'b0}) begin n_fail++; $display("FAIL nxm_code: got code%0d cs%b expected code4 cs0", stat_code, sw_cs); end
        n_checks++; if (stat_addr !== 10'd9) begin n_fail++; $display("FAIL nxm_stat_addr: got %0d expected 9", stat_addr); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        // NXM has priority over DIS: table 0 is disabled and address 9 is above its limit.
        issue(OP_READ, 2'd0, 10'd9, 64'h0);
        n_checks++; if (stat_code !== C_NXM) begin n_fail++; $display("FAIL nxm_over_dis: got %0d expected %0d", stat_code, C_NXM); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        // INIT whose start address lies above its end address
        issue(OP_SET_INIT, 2'd1, 10'd5, 64'h0);
        issue(OP_INIT, 2'd1, 10'd4, 64'h0);
        n_checks++; if (stat_code !== C_NXM) begin n_fail++; $display("FAIL init_range: got %0d expected %0d", stat_code, C_NXM); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        issue(OP_SET_INIT, 2'd1, 10'd0, 64'h0);
        // Unknown opcode. The code is then frozen against other commands.
        issue(4'hC, 2'd1, 10'd0, 64'h0);
        n_checks++; if (stat_code !== C_UOP) begin n_fail++; $display("FAIL uop_code: got %0d expected %0d", stat_code, C_UOP); end
        issue(OP_READ, 2'd1, 10'd1, 64'h0);
        n_checks++; if ({stat_code, sw_cs} !== {C_UOP, 1'b0}) begin n_fail++; $display("FAIL error_frozen: got code%0d cs%b expected code5 cs0", stat_code, sw_cs); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        n_checks++; if ({stat_code, dbg_state} !== {C_RDY, 3'd0}) begin n_fail++; $display("FAIL ack_uop: got code%0d st%0d expected code0 st0", stat_code, dbg_state); end
        // ACK_ERROR in READY has no effect
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        n_checks++; if ({stat_code, dbg_state, sw_cs} !== {C_RDY, 3'd0, 1'b0}) begin n_fail++; $display("FAIL ack_in_ready: got code%0d st%0d cs%b expected code0 st0 cs0", stat_code, dbg_state, sw_cs); end
        // The address at the limit is legal
        issue(OP_READ, 2'd1, 10'd7, 64'h0);
        n_checks++; if ({sw_cs, sw_add} !== {1'b1, 10'd7}) begin n_fail++; $display("FAIL limit_addr_ok: got cs%b a%0d expected cs1 a7", sw_cs, sw_add); end
        grant = 1'b1; tick(1); grant = 1'b0;
        rsp = 1'b1; sw_rdat = 64'h77; tick(1); rsp = 1'b0; sw_rdat = 64'h0;
        n_checks++; if (rd_dat !== 64'h77) begin n_fail++; $display("FAIL limit_read_data: got %h expected 77", rd_dat); end
    endtask

    task automatic test_timeout;
        int busy, first_y;
        busy = 0; first_y = 0;
        issue(OP_READ, 2'd2, 10'd0, 64'h0);
        for (int i = 0; i < 100; i++) begin
            if (stat_code === C_BSY) begin
                busy++;
                if ((yield === 1'b1) && (first_y == 0)) first_y = busy;
            end
            if (stat_code !== C_BSY) break;
            tick(1);
        end
        n_checks++; if (busy !== 63) begin n_fail++; $display("FAIL tmo_busy_cycles: got %0d expected 63", busy); end
        n_checks++; if (first_y !== 32) begin n_fail++; $display("FAIL tmo_yield_cycle: got %0d expected 32", first_y); end
        n_checks++; if ({stat_code, sw_cs, yield} !== {C_TMO, 1'b0, 1'b0}) begin n_fail++; $display("FAIL tmo_code: got code%0d cs%b y%b expected code2 cs0 y0", stat_code, sw_cs, yield); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);

        // A grant in the timeout cycle wins over the timeout
        issue(OP_WRITE, 2'd2, 10'd2, 64'h5);
        tick(62);
        grant = 1'b1; tick(1); grant = 1'b0;
        n_checks++; if ({stat_code, sw_cs} !== {C_RDY, 1'b0}) begin n_fail++; $display("FAIL grant_beats_tmo: got code%0d cs%b expected code0 cs0", stat_code, sw_cs); end
    endtask

    task automatic test_overrun;
        issue(OP_READ, 2'd2, 10'd1, 64'h0);
        grant = 1'b1; tick(1); grant = 1'b0;
        issue(OP_WRITE, 2'd2, 10'd0, 64'h9);
        n_checks++; if ({stat_code, sw_cs} !== {C_OVR, 1'b0}) begin n_fail++; $display("FAIL ovr_code: got code%0d cs%b expected code3 cs0", stat_code, sw_cs); end
        rsp = 1'b1; sw_rdat = 64'h1234; tick(1); rsp = 1'b0; sw_rdat = 64'h0;
        n_checks++; if ({rd_dat, stat_code} !== {64'h77, C_OVR}) begin n_fail++; $display("FAIL ovr_late_rsp: got rd%h code%0d expected rd77 code3", rd_dat, stat_code); end
        issue(OP_ACK, 2'd0, 10'd1, 64'h0);
        n_checks++; if (stat_code !== C_RDY) begin n_fail++; $display("FAIL ovr_ack: got %0d expected 0", stat_code); end
    endtask

    task automatic test_reset_mid;
        issue(OP_ENABLE, 2'd3, 10'd0, 64'h0);
        issue(OP_RESET, 2'd3, 10'd0, 64'h0);
        grant = 1'b1; tick(2);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if ({sw_cs, sw_we, sw_add, stat_code, enable} !== {1'b0, 1'b0, 10'd0, C_RDY, 4'b0}) begin n_fail++; $display("FAIL reset_mid: got cs%b we%b a%0d code%0d en%b expected all zero", sw_cs, sw_we, sw_add, stat_code, enable); end
        grant = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_err_cnt;
`ifdef NX_IA_ERR_CNT_EN
        issue(4'hC, 2'd0, 10'd0, 64'h0);
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt_first: got %0d expected 1", err_cnt); end
        issue(OP_ACK, 2'd0, 10'd5, 64'h0);
        for (int i = 1; i < 300; i++) begin
            issue(4'hC, 2'd0, 10'd0, 64'h0);
            issue(OP_ACK, 2'd0, 10'd5, 64'h0);
        end
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_cnt_sat: got %0d expected 255", err_cnt); end
        issue(4'hC, 2'd0, 10'd0, 64'h0);
        issue(OP_ACK, 2'd0, 10'd0, 64'h0);
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL err_cnt_clear: got %0d expected 0", err_cnt); end
`else
        issue(4'hC, 2'd0, 10'd0, 64'h0);
        n_checks++; if ({err_cnt, stat_code} !== {8'd0, C_UOP}) begin n_fail++; $display("FAIL err_cnt_tied: got cnt%0d code%0d expected cnt0 code5", err_cnt, stat_code); end
        issue(OP_ACK, 2'd0, 10'd0, 64'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_sweep();
        test_init();
        test_errors();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_err_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nx_indirect_access_cntrl_v3.md
Name: nx_indirect_access_cntrl_v3

Overview:
- Multi-table indirect-access controller: software issues register-mapped commands that are serialised into single-port accesses on a shared memory port, with grant/rsp handshakes and timeout supervision.
- Successor to the single-enable controller. Adds:
  - per-table power/enable state;
  - a latched command context (address, table, write data);
  - a table-select output;
  - a programmable init window with range checking.
- Sits between the CSR block and an arbitrated memory wrapper.

Parameters:
- CMND_ADDRESS, 0, register address that decodes a command write
- N_REG_ADDR_BITS, 16, width of reg_addr
- N_DATA_BITS, 64, memory word width
- N_TABLES, 4, number of independently enabled tables behind the port
- N_ENTRIES, 1024, entries per table (address width = clog2(N_ENTRIES))
- N_TIMER_BITS, 6, grant/rsp timeout counter width
- RESET_DATA, 0, N_DATA_BITS value written by RESET

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_stb  in  1  CSR write strobe
- reg_addr  in  N_REG_ADDR_BITS  CSR write address
- cmnd_op  in  4  opcode
- cmnd_addr  in  AW  entry address
- cmnd_table_id  in  TW=max(1,clog2(N_TABLES))  target table
- wr_dat  in  N_DATA_BITS  write/init data
- addr_limit  in  N_TABLES x AW  highest legal address per table
- stat_code  out  3  RDY=0, BSY=1, TMO=2, OVR=3, NXM=4, UOP=5, DIS=6
- stat_addr  out  AW  latched command address
- stat_table_id  out  TW  latched table
- rd_dat  out  N_DATA_BITS  read result
- enable  out  N_TABLES  per-table enable
- sw_cs  out  1  access request
- sw_we  out  1  write qualifier
- sw_table_id  out  TW  table select
- sw_add  out  AW  access address
- sw_wdat  out  N_DATA_BITS  access write data
- sw_rdat  in  N_DATA_BITS  read data, valid with rsp
- grant  in  1  access accepted
- rsp  in  1  read data return
- yield  out  1  timer MSB; arbiter priority hint
- err_cnt  out  8  error count (see optional feature)

Behaviour:
- **Reset values:** stat_code=RDY, state=READY, enable=0, rd_dat=RESET_DATA, sw_cs=sw_we=0, sw_add=0, sw_table_id=0, sw_wdat=0, stat_addr=0, stat_table_id=0, timer=0, init_start=0, err_cnt=0, yield=0.
- **Command issue:** issued when wr_stb && reg_addr==CMND_ADDRESS && op!=NOP. On issue, cmnd_addr, cmnd_table_id and wr_dat are latched; later input changes have no effect.
- **Opcodes:**
  - 1 READ, 2 WRITE: single access.
  - 3 ENABLE, 4 DISABLE: set/clear enable[table] the next cycle; no access; remain READY.
  - 5 RESET: write RESET_DATA to 0..addr_limit[table].
  - 6 INIT: write latched wr_dat to init_start..cmnd_addr.
  - 8 SET_INIT_START: init_start<=cmnd_addr; no access.
  - F ACK_ERROR.
  - Any other opcode: UOP.
- **States:** READY, ACCESS, WAIT_RSP, SWEEP, ERROR.
- **Checks in READY, in priority order UOP > NXM > DIS:**
  - table_id>=N_TABLES, or addr>addr_limit[table], or INIT with init_start>cmnd_addr -> NXM.
  - READ/WRITE/RESET/INIT on a disabled table -> DIS.
  - Failures go to ERROR with no memory access.
- **READY transitions:** READ/WRITE -> ACCESS; RESET/INIT -> SWEEP. Registered outputs, so sw_cs rises the cycle after issue.
- **ACCESS:**
  - sw_cs=1; sw_we=1 for WRITE.
  - On grant: WRITE -> READY; READ -> WAIT_RSP with sw_cs low the next cycle.
  - sw_cs is held until grant; sw_add, sw_table_id and sw_wdat are stable while sw_cs=1.
- **WAIT_RSP:** on rsp, rd_dat<=sw_rdat and state -> READY. stat_code=RDY in the cycle after rsp.
- **SWEEP:**
  - sw_cs=sw_we=1; one address per grant, starting at 0 (RESET) or init_start (INIT).
  - The grant at the last address -> READY.
  - init_start returns to 0 after either sweep completes.
- **Timeout:** timer increments each cycle in ACCESS, WAIT_RSP or SWEEP; clears on grant, on rsp, and in READY/ERROR. Reaching all-ones -> ERROR, code TMO, sw_cs dropped the next cycle.
- **Overrun:** any issued command other than ACK_ERROR while busy -> ERROR, code OVR; the outstanding access is abandoned and a late rsp is ignored.
- **ERROR:** stat_code is frozen at the first cause. Only ACK_ERROR -> READY (stat_code=RDY); all other commands are ignored without changing the code.
- **Simultaneous events:** grant and timeout in the same cycle: grant wins. ACK_ERROR while not in ERROR: no effect.
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronous reset).
- **Status outputs:**
  - stat_code=BSY in ACCESS, WAIT_RSP and SWEEP.
  - stat_addr/stat_table_id show the latched command.

Optional Feature:
- Macro: NX_IA_ERR_CNT_EN.
- With the macro: err_cnt increments on each entry into ERROR, saturates at 255, and clears on ACK_ERROR only when cmnd_addr==0.
- Without the macro: err_cnt is tied to 0 and no counter flops exist.

Test Plan:
- ENABLE table 2; WRITE addr 5 data 0xA5A5, grant after 3 cycles -> sw_cs high 3 cycles, sw_table_id=2, sw_add=5, sw_wdat=0xA5A5; READ addr 5, rsp returns 0xA5A5 -> rd_dat=0xA5A5, stat_code RDY.
- addr_limit[1]=7, table 1 enabled; RESET with grant held 1 -> exactly 8 sw_we pulses, sw_add 0..7, sw_wdat=RESET_DATA, then RDY.
- SET_INIT_START 3; INIT addr 6 data 0x11 -> writes at addrs 3,4,5,6; a following INIT addr 1 writes 0..1.
- READ on disabled table 0 -> stat_code DIS, no sw_cs; READ addr 9 with addr_limit=7 -> NXM; op 0xC -> UOP; ACK_ERROR -> RDY.
- READ with grant never asserted, N_TIMER_BITS=6 -> TMO after 63 busy cycles, yield high from busy cycle 32; WRITE issued while busy -> OVR.
- NX_IA_ERR_CNT_EN defined: 300 errors each followed by ACK_ERROR with cmnd_addr!=0 -> err_cnt=255; ACK_ERROR with cmnd_addr=0 -> 0.
